// File: rtl/gpio_filter_pkg.sv
// gpio_filter_pkg: shared types and constants for the time-multiplexed GPIO
// input filter (scan FSM states, config request record, default threshold).
package gpio_filter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // Width of a channel index; never below one bit so a 1-channel build still elaborates.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  localparam int DefNumCh    = 8;
  localparam int DefCntWidth = 4;
  localparam int DefChW      = ch_idx_w(DefNumCh);

  typedef struct packed {
    logic [DefChW-1:0]      ch;
    logic                   en;
    logic [DefCntWidth-1:0] thresh;
  } cfg_req_t;

  // All-ones threshold after reset; users slice it to their counter width.
  localparam logic [31:0] DefaultThresh = '1;

endpackage

// File: rtl/gpio_filter_scan_if.sv
// gpio_filter_scan_if: valid/ready configuration port of the GPIO filter.
// The master drives a channel/enable/threshold request; the slave accepts it
// and reports an out-of-range channel with a one-cycle error pulse.
interface gpio_filter_scan_if #(
  parameter int NumCh    = 8,
  parameter int CntWidth = 4
);
  import gpio_filter_pkg::*;

  localparam int ChW = ch_idx_w(NumCh);

  logic                cfg_valid;
  logic                cfg_ready;
  logic [ChW-1:0]      cfg_ch;
  logic                cfg_en;
  logic [CntWidth-1:0] cfg_thresh;
  logic                cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_en, cfg_thresh,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_en, cfg_thresh,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/gpio_filter_presc.sv
// gpio_filter_presc: free-running scan prescaler. tick_o is high in the cycle
// the counter equals presc_i; the counter then wraps to zero.
module gpio_filter_presc #(
  parameter int PrescWidth = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [PrescWidth-1:0] presc_i,
  output logic                  tick_o
);

  logic [PrescWidth-1:0] pc_q;

  assign tick_o = (pc_q == presc_i);

  // Count every cycle regardless of scan state, restarting after each tick.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q <= '0;
    end else if (tick_o) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_q + 1'b1;
    end
  end

endmodule

// File: rtl/gpio_filter_scan.sv
// gpio_filter_scan: time-multiplexed GPIO input filter. Per-channel counter,
// last sample, stored value, enable and threshold live in register arrays and
// one channel is updated per cycle by a shared datapath during a scan.
// Optional macro GPIO_FILTER_EDGE_EVT_EN adds edge_evt_o, a one-cycle pulse per
// enabled channel whenever its stored (filtered) value changes.
module gpio_filter_scan
  import gpio_filter_pkg::*;
#(
  parameter int NumCh      = 8,
  parameter int CntWidth   = 4,
  parameter int PrescWidth = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumCh-1:0]      gpio_i,
  input  logic [PrescWidth-1:0] presc_i,
  gpio_filter_scan_if.slave     cfg,
  input  logic                  ovr_clr_i,
  output logic [NumCh-1:0]      filter_o,
  output logic                  busy_o,
  output logic                  overrun_o
`ifdef GPIO_FILTER_EDGE_EVT_EN
  ,
  output logic [NumCh-1:0]      edge_evt_o
`endif
);

  localparam int             ChW     = ch_idx_w(NumCh);
  localparam logic [ChW-1:0] LastIdx = ChW'(NumCh - 1);

  logic                tick;
  scan_state_e         state_q, state_n;
  logic [ChW-1:0]      idx_q, idx_n;
  logic                scanning;
  logic                cfg_ready;
  logic                cfg_accept;
  logic                cfg_ch_ok;

  logic [CntWidth-1:0] cnt_q    [NumCh];
  logic [CntWidth-1:0] thresh_q [NumCh];
  logic [NumCh-1:0]    last_q;
  logic [NumCh-1:0]    stored_q;
  logic [NumCh-1:0]    en_q;
  logic                ovr_q;
  logic                err_q;

  logic                sample;
  logic [CntWidth-1:0] cur_cnt;
  logic [CntWidth-1:0] cur_thr;
  logic [CntWidth-1:0] cnt_n;
  logic                store_hit;

  gpio_filter_presc #(
    .PrescWidth (PrescWidth)
  ) u_presc (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .presc_i (presc_i),
    .tick_o  (tick)
  );

  // Scan state and channel pointer; reset aborts any scan in progress.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
    end
  end

  // A tick starts a scan at channel 0; the scan walks every channel once and ends.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_n = SCAN;
          idx_n   = '0;
        end
      end
      SCAN: begin
        if (idx_q == LastIdx) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          idx_n = idx_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  // Config is only taken while idle and not about to start a scan.
  always_comb begin
    scanning  = (state_q == SCAN);
    busy_o    = scanning;
    cfg_ready = (state_q == IDLE) && !tick;
  end

  assign cfg.cfg_ready = cfg_ready;
  assign cfg.cfg_err   = err_q;
  assign cfg_accept    = cfg.cfg_valid && cfg_ready;
  assign cfg_ch_ok     = (int'(cfg.cfg_ch) < NumCh);

  // Shared update datapath for the channel under the scan pointer.
  always_comb begin
    sample  = gpio_i[idx_q];
    cur_cnt = cnt_q[idx_q];
    cur_thr = thresh_q[idx_q];
    if (sample != last_q[idx_q]) begin
      cnt_n = '0;
    end else if (cur_cnt >= cur_thr) begin
      cnt_n = cur_thr;
    end else begin
      cnt_n = cur_cnt + 1'b1;
    end
    store_hit = (cnt_n == cur_thr);
  end

  // Channel arrays: scan writeback and runtime config (never in the same cycle).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumCh; i++) begin
        cnt_q[i]    <= '0;
        thresh_q[i] <= DefaultThresh[CntWidth-1:0];
      end
      last_q   <= '0;
      stored_q <= '0;
      en_q     <= '0;
    end else begin
      if (scanning) begin
        cnt_q[idx_q]  <= cnt_n;
        last_q[idx_q] <= sample;
        if (store_hit) begin
          stored_q[idx_q] <= sample;
        end
      end
      if (cfg_accept && cfg_ch_ok) begin
        en_q[cfg.cfg_ch]     <= cfg.cfg_en;
        thresh_q[cfg.cfg_ch] <= cfg.cfg_thresh;
        cnt_q[cfg.cfg_ch]    <= '0;
      end
    end
  end

  // Sticky overrun (a new tick beats a simultaneous clear) and config error pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ovr_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (tick && scanning) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr_i) begin
        ovr_q <= 1'b0;
      end
      err_q <= cfg_accept && !cfg_ch_ok;
    end
  end

  assign overrun_o = ovr_q;
  assign filter_o  = (en_q & stored_q) | (~en_q & gpio_i);

`ifdef GPIO_FILTER_EDGE_EVT_EN
  logic [NumCh-1:0] evt_q;

  // Flag an enabled channel whose stored value is about to flip this cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      evt_q <= '0;
    end else begin
      evt_q <= '0;
      if (scanning && store_hit && (sample != stored_q[idx_q]) && en_q[idx_q]) begin
        evt_q[idx_q] <= 1'b1;
      end
    end
  end

  assign edge_evt_o = evt_q;
`endif

endmodule
